pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Registered program-counter unit for the next-generation processor: holds the PC, computes the next fetch address, and updates the PC every cycle.
- Generalises next-PC selection to a parametrised address width and instruction size. Supports CBZ/CBNZ conditional branches, unconditional branches, register branches, and branch-with-link.
- Includes a RAS_DEPTH-entry return-address stack for call/return prediction.
- Sits between the control unit/ALU and the instruction memory address port.

Parameters:
- WIDTH, 64, address/immediate width in bits
- SHIFT, 2, left shift applied to the branch immediate (log2 of instruction bytes)
- RAS_DEPTH, 4, return-address stack entries (power of 2, at least 2)
- RESET_PC, 0, PC value loaded by reset

Ports:
- CLK  input  1  clock; all state updates on rising edge
- Reset_L  input  1  asynchronous, active-low reset
- Stall  input  1  hold PC and RAS this cycle
- Branch  input  1  conditional branch instruction
- BranchNot  input  1  with Branch: take on ALUZero==0 (CBNZ)
- ALUZero  input  1  ALU zero flag
- Uncondbranch  input  1  PC-relative unconditional branch
- RegBranch  input  1  register-indirect branch (BR)
- Link  input  1  push return address (valid with Uncondbranch or RegBranch)
- Return  input  1  pop RAS and branch to popped address (RET)
- Imm  input  WIDTH  sign-extended branch offset, in instructions
- RegTarget  input  WIDTH  register branch target, in bytes
- CurrentPC  output  WIDTH  registered PC
- NextPC  output  WIDTH  combinational next PC
- Taken  output  1  combinational; next PC is not sequential
- LinkAddr  output  WIDTH  CurrentPC + 2^SHIFT
- RasEmpty  output  1  stack count == 0
- RasFull  output  1  stack count == RAS_DEPTH
- RasOverflow  output  1  sticky; a push dropped the oldest entry
- RasUnderflow  output  1  sticky; Return was issued while the stack was empty
- MisalignErr  output  1  combinational; RegBranch target has nonzero low SHIFT bits

Behaviour:
- Reset (asynchronous, while Reset_L==0):
  - CurrentPC=RESET_PC.
  - RAS count=0, top pointer=0, RasOverflow=0, RasUnderflow=0.
  - Entry contents are don't-care.
- Arithmetic: all sums are modulo 2^WIDTH, with wrap-around and no error.
  - Sequential: SeqPC = CurrentPC + 2^SHIFT.
  - PC-relative: BrPC = CurrentPC + (Imm << SHIFT); bits shifted out are discarded.
- Target priority, highest first:
  1. Return with RAS non-empty: NextPC = top entry.
  2. RegBranch: NextPC = RegTarget with the low SHIFT bits forced to 0.
  3. Uncondbranch: NextPC = BrPC.
  4. Branch && (ALUZero ^ BranchNot): NextPC = BrPC.
  5. Otherwise: NextPC = SeqPC.
- Taken=1 whenever cases 1-4 select the target.
- Return with RAS empty: NextPC=SeqPC, Taken=0, RasUnderflow is set on the clock edge if not stalled.
- Clock edge with Stall=0: CurrentPC<=NextPC. With Stall=1: CurrentPC, RAS and the sticky flags all hold.
- Combinational outputs follow inputs regardless of Stall.
- Push:
  - Occurs when Link && (Uncondbranch || RegBranch) && !Return && !Stall.
  - Writes LinkAddr at top+1 (mod RAS_DEPTH), then top advances.
  - count increments, saturating at RAS_DEPTH.
  - Pushing when full overwrites the oldest entry (circular) and sets RasOverflow.
- Link without Uncondbranch or RegBranch: ignored.
- Pop:
  - Occurs when Return && count>0 && !Stall.
  - top moves back by 1 (mod RAS_DEPTH) and count decrements.
- Link and Return in the same cycle with count>0:
  - Target is the old top entry.
  - The top entry is replaced with LinkAddr.
  - count and top are unchanged.
- Link and Return in the same cycle with count==0: underflow rules apply, and then LinkAddr is pushed.
- Reset asserted mid-operation clears state immediately; the first edge after release fetches from RESET_PC + 2^SHIFT unless a branch is taken.
- Latency: NextPC is combinational (0 cycles); CurrentPC reflects it 1 cycle later.

Test Plan:
- Reset, then 3 idle clocks -> CurrentPC goes 0, 4, 8, 12; Taken=0; RasEmpty=1.
- PC=0x100, Branch=1, BranchNot=0, ALUZero=1, Imm=-2 -> NextPC=0xF8, Taken=1.
  - With ALUZero=0 -> NextPC=0x104.
  - With BranchNot=1 and ALUZero=0 -> NextPC=0xF8.
- PC=0x200, Uncondbranch+Link, Imm=0x10 -> next PC=0x240, RAS top=0x204.
  - Later Return -> PC=0x204, RasEmpty=1.
- Five BL calls with RAS_DEPTH=4 -> RasFull=1, RasOverflow=1.
  - Five Returns yield the four newest addresses in LIFO order, then fall through with RasUnderflow=1.
- RegBranch, RegTarget=0x303 -> NextPC=0x300, MisalignErr=1.
  - Same request with Stall=1 -> CurrentPC and RAS unchanged.
- PC=0xFFFF_FFFF_FFFF_FFFC, idle clock -> PC=0. Reset pulsed mid-stack -> count=0 and flags cleared asynchronously before the next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter unit: registered PC, next-fetch-address selection and a
// circular return-address stack for call/return prediction.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      SHIFT     = 2,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             BranchNot,
    input  logic             ALUZero,
    input  logic             Uncondbranch,
    input  logic             RegBranch,
    input  logic             Link,
    input  logic             Return,
    input  logic [WIDTH-1:0] Imm,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] CurrentPC,
    output logic [WIDTH-1:0] NextPC,
    output logic             Taken,
    output logic [WIDTH-1:0] LinkAddr,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasOverflow,
    output logic             RasUnderflow,
    output logic             MisalignErr
);

    localparam int unsigned      PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INSN_BYTES = WIDTH'(1) << SHIFT;
    localparam logic [WIDTH-1:0] LOW_MASK   = INSN_BYTES - WIDTH'(1);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             unf;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_pc;
    logic [WIDTH-1:0] next_pc;
    logic             taken;
    logic             ras_hit;
    logic             link_req;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    always_comb begin
        seq_pc   = pc + INSN_BYTES;
        br_pc    = pc + (Imm << SHIFT);
        ras_hit  = Return && (count != '0);
        link_req = Link && (Uncondbranch || RegBranch);
        next_pc  = seq_pc;
        taken    = 1'b1;
        if (ras_hit) begin
            next_pc = ras[top];
        end else if (RegBranch) begin
            next_pc = RegTarget & ~LOW_MASK;
        end else if (Uncondbranch) begin
            next_pc = br_pc;
        end else if (Branch && (ALUZero ^ BranchNot)) begin
            next_pc = br_pc;
        end else begin
            taken = 1'b0;
        end
        // A call that is also a return reuses the top slot; an empty-stack
        // return degrades to a plain push of the link address.
        do_push    = link_req && !ras_hit;
        do_replace = link_req && ras_hit;
        do_pop     = ras_hit && !link_req;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc    <= RESET_PC;
            top   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (!Stall) begin
            pc <= next_pc;
            if (Return && (count == '0)) begin
                unf <= 1'b1;
            end
            if (do_push) begin
                top <= top + PTR_W'(1);
                if (count == CNT_FULL) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_pop) begin
                top   <= top - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry contents need no reset; only count/top define validity.
    always_ff @(posedge CLK) begin
        if (!Stall) begin
            if (do_push) begin
                ras[top + PTR_W'(1)] <= seq_pc;
            end else if (do_replace) begin
                ras[top] <= seq_pc;
            end
        end
    end

    assign CurrentPC    = pc;
    assign NextPC       = next_pc;
    assign Taken        = taken;
    assign LinkAddr     = seq_pc;
    assign RasEmpty     = (count == '0);
    assign RasFull      = (count == CNT_FULL);
    assign RasOverflow  = ovf;
    assign RasUnderflow = unf;
    assign MisalignErr  = RegBranch && ((RegTarget & LOW_MASK) != '0);

endmodule
